trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_pkg.sv | 28 ++
 rtl/trap_prio_enc.sv | 28 ++
 rtl/trap_ctrl.sv | 173 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// trap_pkg -- shared definitions for the trap controller.
//   CSR address constants, the controller state encoding, the source index
//   width and the mcause encoding helper (cause = source index + 1).
package trap_pkg;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;
    localparam logic [11:0] CSR_MIE    = 12'h304;
    localparam logic [11:0] CSR_MIP    = 12'h344;
    localparam logic [11:0] CSR_MIPD   = 12'h100;

    // Up to 16 sources, so a 4-bit index covers every configuration.
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } trap_state_t;

    function automatic logic [31:0] cause_of(input logic [IDX_W-1:0] idx);
        return {{(32-IDX_W){1'b0}}, idx} + 32'd1;
    endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc -- fixed-priority encoder, bit 0 highest priority.
//   Parameter NUM_SRC : request width (1..16)
//   req   in  NUM_SRC  request vector
//   valid out 1        any request bit set
//   idx   out 4        index of the lowest set bit (0 when valid=0)
module trap_prio_enc
    import trap_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Scan from the top so the lowest set index is the last to assign.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl -- machine-mode trap controller with a small CSR file.
//   Takes the highest-priority enabled pending source, captures pc/tval/cause,
//   redirects the PC to the trap vector, waits for the handler to write
//   mipd[0]=1, then redirects back to mepc.
//   Optional feature macro: TRAP_CTRL_VECTOR_EN (vectored mode via mtvec[0]).
//   Parameters: NUM_SRC (1..16), VEC_BASE (reset value of mtvec)
//   Ports:
//     clk, rstn          clock, asynchronous active-low reset
//     trap_req           level trap requests, bit 0 highest priority
//     trap_pc, trap_tval PC and trap value captured for the taken request
//     csr_radd/csr_dout  combinational CSR read port (0 when unmapped)
//     csr_wadd/csr_din/csr_wen  CSR write port
//     pc_redirect, pc_target    one-cycle redirect and its address
//     pipe_flush         pipeline flush, equal to pc_redirect
//     in_handler         high in HANDLER and RETURN
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int          NUM_SRC  = 4,
    parameter logic [31:0] VEC_BASE = 32'h0000F000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_SRC-1:0] trap_req,
    input  logic [31:0]        trap_pc,
    input  logic [31:0]        trap_tval,
    input  logic [11:0]        csr_radd,
    output logic [31:0]        csr_dout,
    input  logic [11:0]        csr_wadd,
    input  logic [31:0]        csr_din,
    input  logic               csr_wen,
    output logic               pc_redirect,
    output logic [31:0]        pc_target,
    output logic               pipe_flush,
    output logic               in_handler
);

    trap_state_t state, state_next;

    logic [31:0]        mtvec, mcause, mepc, mtval;
    logic [NUM_SRC-1:0] mie, mip;
    logic               mipd;

    logic [NUM_SRC-1:0] mip_fold, pending, clr_mask;
    logic               win_valid, take, ret_req;
    logic [IDX_W-1:0]   win_idx;
    logic [31:0]        vector;

    // New requests count in the same cycle they arrive.
    assign mip_fold = mip | trap_req;
    assign pending  = mip_fold & mie;

    trap_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
        .req   (pending),
        .valid (win_valid),
        .idx   (win_idx)
    );

    assign take    = (state == ST_IDLE) && win_valid;
    assign ret_req = csr_wen && (csr_wadd == CSR_MIPD) && csr_din[0];

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            clr_mask[i] = take && (win_idx == IDX_W'(i));
        end
    end

`ifdef TRAP_CTRL_VECTOR_EN
    // Vectored mode places each cause 4 bytes apart from the aligned base.
    always_comb begin
        if (mtvec[0])
            vector = {mtvec[31:2], 2'b00} + ((mcause - 32'd1) << 2);
        else
            vector = {mtvec[31:2], 2'b00};
    end
`else
    assign vector = mtvec;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        pc_redirect = 1'b0;
        pc_target   = 32'd0;
        in_handler  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_valid) state_next = ST_ENTER;
            end
            ST_ENTER: begin
                pc_redirect = 1'b1;
                pc_target   = vector;
                state_next  = ST_HANDLER;
            end
            ST_HANDLER: begin
                in_handler = 1'b1;
                if (ret_req) state_next = ST_RETURN;
            end
            ST_RETURN: begin
                pc_redirect = 1'b1;
                pc_target   = mepc;
                in_handler  = 1'b1;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign pipe_flush = pc_redirect;

    // A trap capture overrides a CSR write to the same register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
`ifdef TRAP_CTRL_VECTOR_EN
            mtvec <= VEC_BASE;
`else
            mtvec <= {VEC_BASE[31:2], 2'b00};
`endif
            mcause <= 32'd0;
            mepc   <= 32'd0;
            mtval  <= 32'd0;
            mie    <= '1;
            mip    <= '0;
            mipd   <= 1'b0;
        end else begin
            mip <= mip_fold & ~clr_mask;

            if (csr_wen && csr_wadd == CSR_MTVEC) begin
`ifdef TRAP_CTRL_VECTOR_EN
                mtvec <= csr_din;
`else
                mtvec <= {csr_din[31:2], 2'b00};
`endif
            end

            if (csr_wen && csr_wadd == CSR_MIE) mie <= csr_din[NUM_SRC-1:0];

            if (take) begin
                mepc   <= trap_pc;
                mtval  <= trap_tval;
                mcause <= cause_of(win_idx);
            end else begin
                if (csr_wen && csr_wadd == CSR_MEPC)   mepc   <= csr_din;
                if (csr_wen && csr_wadd == CSR_MTVAL)  mtval  <= csr_din;
                if (csr_wen && csr_wadd == CSR_MCAUSE) mcause <= csr_din;
            end

            if (take || state == ST_RETURN)
                mipd <= 1'b0;
            else if (csr_wen && csr_wadd == CSR_MIPD)
                mipd <= csr_din[0];
        end
    end

    always_comb begin
        csr_dout = 32'd0;
        case (csr_radd)
            CSR_MTVEC:  csr_dout = mtvec;
            CSR_MCAUSE: csr_dout = mcause;
            CSR_MEPC:   csr_dout = mepc;
            CSR_MTVAL:  csr_dout = mtval;
            CSR_MIE:    csr_dout[NUM_SRC-1:0] = mie;
            CSR_MIP:    csr_dout[NUM_SRC-1:0] = mip;
            CSR_MIPD:   csr_dout[0] = mipd;
            default:    csr_dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl -- directed self-checking bench for trap_ctrl (NUM_SRC=4).
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  trap_req;
    logic [31:0] trap_pc, trap_tval;
    logic [11:0] csr_radd, csr_wadd;
    logic [31:0] csr_dout, csr_din;
    logic        csr_wen;
    logic        pc_redirect, pipe_flush, in_handler;
    logic [31:0] pc_target;

    int n_assert = 0;
    int n_fail   = 0;

    trap_ctrl #(.NUM_SRC(4), .VEC_BASE(32'h0000F000)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .trap_req    (trap_req),
        .trap_pc     (trap_pc),
        .trap_tval   (trap_tval),
        .csr_radd    (csr_radd),
        .csr_dout    (csr_dout),
        .csr_wadd    (csr_wadd),
        .csr_din     (csr_din),
        .csr_wen     (csr_wen),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .pipe_flush  (pipe_flush),
        .in_handler  (in_handler)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
        csr_radd = addr;
        #1;
        chk(tag, csr_dout, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        csr_wen  = 1'b1;
        csr_wadd = addr;
        csr_din  = data;
    endtask

    // Out of HANDLER: request return, pass through RETURN, land in IDLE.
    task automatic do_return();
        wr(12'h100, 32'd1);
        step();
        csr_wen = 1'b0;
        step();
    endtask

    task automatic outs(input string tag, input logic red, input logic [31:0] tgt,
                        input logic inh);
        chk({tag, "_redirect"}, {31'd0, pc_redirect}, {31'd0, red});
        chk({tag, "_flush"},    {31'd0, pipe_flush},  {31'd0, red});
        chk({tag, "_target"},   pc_target, tgt);
        chk({tag, "_in_hdl"},   {31'd0, in_handler},  {31'd0, inh});
    endtask

    initial begin
        rstn = 1'b0; trap_req = '0; trap_pc = '0; trap_tval = '0;
        csr_radd = '0; csr_wadd = '0; csr_din = '0; csr_wen = 1'b0;
        #25;
        outs("rst", 1'b0, 32'd0, 1'b0);
        rd(12'h305, 32'h0000F000, "rst_mtvec");
        rd(12'h304, 32'h0000000F, "rst_mie");
        rd(12'h342, 32'h0, "rst_mcause");
        rd(12'h344, 32'h0, "rst_mip");
        rd(12'h100, 32'h0, "rst_mipd");
        rstn = 1'b1;
        step();

        // Single trap from source 2
        trap_req = 4'b0100; trap_pc = 32'h40; trap_tval = 32'h7;
        step();
        trap_req = '0;
        outs("enter1", 1'b1, 32'h0000F000, 1'b0);
        rd(12'h342, 32'd3, "t1_mcause");
        rd(12'h341, 32'h40, "t1_mepc");
        rd(12'h343, 32'h7, "t1_mtval");
        rd(12'h344, 32'h0, "t1_mip");
        step();
        outs("hdl1", 1'b0, 32'd0, 1'b1);
        step();
        outs("hdl1b", 1'b0, 32'd0, 1'b1);
        wr(12'h100, 32'd1);
        step();
        csr_wen = 1'b0;
        outs("ret1", 1'b1, 32'h40, 1'b1);
        rd(12'h100, 32'd1, "ret1_mipd");
        step();
        outs("idle1", 1'b0, 32'd0, 1'b0);
        rd(12'h100, 32'd0, "idle1_mipd");

        // Two simultaneous requests: source 1 first, source 3 after return
        trap_req = 4'b1010; trap_pc = 32'h100; trap_tval = 32'h11;
        step();
        trap_req = '0; trap_pc = 32'h200;
        outs("enter2", 1'b1, 32'h0000F000, 1'b0);
        rd(12'h342, 32'd2, "t2_mcause");
        rd(12'h344, 32'h8, "t2_mip");
        step();
        wr(12'h100, 32'd1);
        step();
        csr_wen = 1'b0;
        outs("ret2", 1'b1, 32'h100, 1'b1);
        step();
        outs("idle2", 1'b0, 32'd0, 1'b0);
        rd(12'h344, 32'h8, "idle2_mip");
        step();
        outs("enter3", 1'b1, 32'h0000F000, 1'b0);
        rd(12'h342, 32'd4, "t3_mcause");
        rd(12'h341, 32'h200, "t3_mepc");
        rd(12'h344, 32'h0, "t3_mip");
        step();
        do_return();

        // Masked source stays pending until enabled
        wr(12'h304, 32'hD);
        step();
        csr_wen = 1'b0;
        rd(12'h304, 32'hD, "mie_d");
        trap_req = 4'b0010; trap_pc = 32'h300;
        step();
        trap_req = '0;
        outs("masked", 1'b0, 32'd0, 1'b0);
        rd(12'h344, 32'h2, "masked_mip");
        step();
        outs("masked2", 1'b0, 32'd0, 1'b0);
        wr(12'h304, 32'hF);
        step();
        csr_wen = 1'b0;
        outs("unmask", 1'b0, 32'd0, 1'b0);
        step();
        outs("enter4", 1'b1, 32'h0000F000, 1'b0);
        rd(12'h342, 32'd2, "t4_mcause");
        rd(12'h344, 32'h0, "t4_mip");
        step();
        do_return();

        // Capture beats a simultaneous mepc write
        wr(12'h341, 32'h99);
        trap_req = 4'b0001; trap_pc = 32'h20; trap_tval = 32'h5;
        step();
        csr_wen = 1'b0; trap_req = '0;
        outs("enter5", 1'b1, 32'h0000F000, 1'b0);
        rd(12'h341, 32'h20, "t5_mepc");
        rd(12'h342, 32'd1, "t5_mcause");
        step();
        do_return();

        // Read-only and unmapped writes are dropped
        wr(12'h344, 32'hF);
        step();
        wr(12'h123, 32'hDEAD);
        step();
        csr_wen = 1'b0;
        rd(12'h344, 32'h0, "mip_ro");
        rd(12'h123, 32'h0, "unmapped");
        wr(12'h341, 32'h1234);
        step();
        csr_wen = 1'b0;
        rd(12'h341, 32'h1234, "mepc_wr");

        // Vector mode handling of mtvec
        wr(12'h305, 32'hF001);
        step();
        csr_wen = 1'b0;
`ifdef TRAP_CTRL_VECTOR_EN
        rd(12'h305, 32'hF001, "mtvec_rd");
`else
        rd(12'h305, 32'hF000, "mtvec_rd");
`endif
        trap_req = 4'b0100; trap_pc = 32'h60;
        step();
        trap_req = '0;
`ifdef TRAP_CTRL_VECTOR_EN
        outs("enter6", 1'b1, 32'h0000F008, 1'b0);
`else
        outs("enter6", 1'b1, 32'h0000F000, 1'b0);
`endif
        step();
        outs("hdl6", 1'b0, 32'd0, 1'b1);

        // Reset inside the handler with a request pending
        trap_req = 4'b0001;
        step();
        trap_req = '0;
        rd(12'h344, 32'h1, "pend_mip");
        rstn = 1'b0;
        #1;
        outs("rst2", 1'b0, 32'd0, 1'b0);
        rd(12'h344, 32'h0, "rst2_mip");
        rd(12'h342, 32'h0, "rst2_mcause");
        rd(12'h305, 32'h0000F000, "rst2_mtvec");
        step();
        rstn = 1'b1;
        step();
        outs("post_rst", 1'b0, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
